conv_stream_postproc: RTL
=========================

Name: conv_stream_postproc

Overview:
- Receiving end of the convolution core's 64-bit master AXI-Stream. Each beat carries one accumulated 48-bit pixel, sign-extended to 64 bits.
- Per beat: rounding requantisation to 16-bit fixed point, optional noise add, LeakyReLU, saturation.
- Emits a 16-bit AXI-Stream in the same pixel format the convolution core's slave port consumes, so layers can be chained.
- Carries tlast through and checks frame length; sticky error flags go to the control unit.

Parameters:
- ACC_WIDTH, 48, significant accumulator bits in s_axis_tdata[ACC_WIDTH-1:0].
- OUT_WIDTH, 16, output pixel width (signed).
- FRAC_SHIFT, 8, arithmetic right shift applied to the accumulator (Q.16 products to Q8.8); must be 1 or more.
- LEAKY_SHIFT, 3, negative-slope shift; slope = 2^-LEAKY_SHIFT.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- image_size  in  8  frame side length (4..128); expected beats per frame = image_size^2.
- noise_scale  in  16  signed Q8.8 noise weight; used only when the noise feature is compiled in.
- clr_status  in  1  synchronous clear of sticky flags and pixel counter.
- s_axis_tdata  in  64  accumulator beat.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  last pixel of the channel frame.
- m_axis_tdata  out  16  processed pixel.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  registered copy of the input tlast.
- sat_flag  out  1  sticky: at least one output was saturated.
- acc_err  out  1  sticky: s_axis_tdata[63:ACC_WIDTH] was not all copies of bit ACC_WIDTH-1.
- tlast_err  out  1  sticky: tlast arrived on a beat other than beat image_size^2, or was missing on that beat.
- pixel_count  out  15  beats accepted in the current frame.

Behaviour:
- Reset values: all pipeline valids 0; m_axis_tdata, m_axis_tlast, sat_flag, acc_err, tlast_err and pixel_count all 0; m_axis_tvalid 0; LFSR = 16'hACE1.
- Pipeline: 3 stages (S1, S2, S3), each with its own valid and tlast registers. S3 drives the m_axis outputs directly.
- Global advance: adv = !v3 | m_axis_tready.
  - s_axis_tready = adv (combinational).
  - A beat is accepted when s_axis_tvalid & adv.
  - When adv = 0, every stage holds its contents; no beat is lost or duplicated.
  - Latency is 3 cycles from acceptance to m_axis_tvalid when there is no backpressure; throughput is 1 beat per cycle.
- Once m_axis_tvalid is high, m_axis_tdata and m_axis_tlast stay stable until the handshake completes (AXI rule).
- S1: acc = signed s_axis_tdata[ACC_WIDTH-1:0]; r = (acc + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT, width ACC_WIDTH. acc_err is set here when the upper-bits check fails.
- S2: x = r, plus the noise term if compiled in. If x < 0 then y = x >>> LEAKY_SHIFT (floor), else y = x.
- S3: y is clamped to [-32768, 32767]. sat_flag is set whenever clamping changes the value.
- Frame check, on each accepted beat:
  - pixel_count increments.
  - If tlast is high, or pixel_count+1 == image_size^2: tlast_err is set when exactly one of those two conditions holds; pixel_count then returns to 0.
  - The expected count wraps at 16384 (image_size 128).
- Simultaneous events: clr_status has priority over setting any sticky flag in the same cycle. Counter clear and beat acceptance in the same cycle give pixel_count = 1.
- Reset mid-frame discards all in-flight beats; the upstream core must restart the frame.
- image_size must stay constant while a frame is in flight; a change mid-frame is undefined.

Optional Feature:
- Macro: CONV_POSTPROC_NOISE_EN.
- Defined:
  - 16-bit Fibonacci LFSR, taps 16, 14, 13, 11.
  - The LFSR advances once per accepted beat.
  - Noise term n = (signed lfsr * signed noise_scale) >>> 8, sign-extended to ACC_WIDTH.
  - n is added in S2 before LeakyReLU.
- Undefined: no LFSR or multiplier is built; noise_scale is ignored; n = 0.

Decomposition:
- Shared package conv_pkg holds:
  - constants ACC_WIDTH, PIX_WIDTH = 16, AXIS_ACC_WIDTH = 64;
  - PIX_MAX / PIX_MIN;
  - LFSR seed and tap mask;
  - a typedef for the signed pixel.
- Natural sub-module: conv_noise_lfsr (LFSR plus scale multiply), instantiated only under CONV_POSTPROC_NOISE_EN.

Test Plan:
- Rounding, with m_axis_tready held at 1:
  - tdata 0x300 → m_axis_tdata 0x0003 on the 3rd cycle after acceptance.
  - tdata 0x180 → 0x0002.
- LeakyReLU: tdata 0xFFFF_FFFF_FFFF_F800 (-2048) → r = -8 → 0xFFFF (-1); sat_flag stays 0.
- Saturation: tdata 0x0000_0000_7FFF_FF00 → 0x7FFF and sat_flag = 1; then clr_status pulse → sat_flag = 0.
- Backpressure:
  - Stream 0x100, 0x200, … 0x800 with m_axis_tready low for 5 cycles mid-stream.
  - Outputs must be 0x0001..0x0008 in order; s_axis_tready low while S3 is full and stalled; tdata stable while stalled.
- Framing with image_size = 4:
  - tlast on beat 16 → m_axis_tlast on the 16th output, tlast_err = 0, pixel_count = 0 afterwards.
  - Next frame with tlast on beat 15 → tlast_err = 1.
- Upper-bit check and reset: tdata 0x0001_0000_0000_0100 → acc_err = 1. Asserting reset mid-frame with 2 beats in flight → m_axis_tvalid = 0 and all flags 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/conv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | conv_pkg                                                             |
// | Shared constants and types for the convolution stream path.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package conv_pkg;

  localparam int ACC_WIDTH      = 48;
  localparam int PIX_WIDTH      = 16;
  localparam int AXIS_ACC_WIDTH = 64;

  typedef logic signed [PIX_WIDTH-1:0] pix_t;

  localparam pix_t PIX_MAX = pix_t'(16'h7FFF);
  localparam pix_t PIX_MIN = pix_t'(16'h8000);

  // Fibonacci taps 16,14,13,11 expressed as a bit mask over lfsr[15:0]
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage
`default_nettype wire

// File: rtl/conv_stream_postproc_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | conv_stream_postproc_if                                              |
// | AXI-Stream bundle (data/valid/ready/last) with master/slave views.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface conv_stream_postproc_if #(
  parameter int WIDTH = conv_pkg::AXIS_ACC_WIDTH
);
  logic [WIDTH-1:0] tdata;
  logic             tvalid;
  logic             tready;
  logic             tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/conv_noise_lfsr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | conv_noise_lfsr                                                      |
// | 16-bit Fibonacci LFSR scaled by a signed Q8.8 weight.                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module conv_noise_lfsr #(
  parameter int ACC_WIDTH = 48
) (
  input  wire                         clk,
  input  wire                         reset,
  input  wire                         advance,
  input  wire  signed [15:0]          noise_scale,
  output logic signed [ACC_WIDTH-1:0] noise
);
  import conv_pkg::*;

  logic [15:0]        r_lfsr;
  logic               w_fb;
  logic signed [31:0] w_prod;

  assign w_fb = ^(r_lfsr & LFSR_TAPS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr <= LFSR_SEED;
    end else if (advance) begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
    end
  end

  assign w_prod = signed'(r_lfsr) * noise_scale;
  assign noise  = ACC_WIDTH'(w_prod >>> 8);

endmodule
`default_nettype wire

// File: rtl/conv_stream_postproc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | conv_stream_postproc                                                 |
// | Requantise / LeakyReLU / saturate 48-bit accumulators to 16-bit      |
// | pixels, with frame-length checking. Noise injection is built only    |
// | when CONV_POSTPROC_NOISE_EN is defined.                              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module conv_stream_postproc #(
  parameter int ACC_WIDTH   = conv_pkg::ACC_WIDTH,
  parameter int OUT_WIDTH   = conv_pkg::PIX_WIDTH,
  parameter int FRAC_SHIFT  = 8,
  parameter int LEAKY_SHIFT = 3
) (
  input  wire                clk,
  input  wire                reset,
  input  wire  [7:0]         image_size,
  input  wire  signed [15:0] noise_scale,
  input  wire                clr_status,
  conv_stream_postproc_if.slave  s_axis,
  conv_stream_postproc_if.master m_axis,
  output logic               sat_flag,
  output logic               acc_err,
  output logic               tlast_err,
  output logic [14:0]        pixel_count
);
  import conv_pkg::*;

  localparam logic signed [ACC_WIDTH-1:0] C_HALF = ACC_WIDTH'(1) <<< (FRAC_SHIFT - 1);
  localparam logic signed [ACC_WIDTH-1:0] C_MAX  =
    (ACC_WIDTH'(1) <<< (OUT_WIDTH - 1)) - ACC_WIDTH'(1);
  localparam logic signed [ACC_WIDTH-1:0] C_MIN  = ~C_MAX;

  logic                                 w_adv;
  logic                                 w_accept;
  logic                                 w_acc_bad;
  logic [AXIS_ACC_WIDTH-ACC_WIDTH:0]    w_upper;
  logic signed [ACC_WIDTH-1:0]          w_acc;
  logic signed [ACC_WIDTH-1:0]          w_round;
  logic signed [ACC_WIDTH-1:0]          w_noise;
  logic signed [ACC_WIDTH-1:0]          w_x;
  logic signed [ACC_WIDTH-1:0]          w_y;
  logic                                 w_sat_hi;
  logic                                 w_sat_lo;
  logic [OUT_WIDTH-1:0]                 w_clamp;
  logic [14:0]                          w_frame_len;
  logic                                 w_frame_hit;

  logic                                 r_v1, r_v2, r_v3;
  logic                                 r_l1, r_l2, r_l3;
  logic signed [ACC_WIDTH-1:0]          r_r1;
  logic signed [ACC_WIDTH-1:0]          r_n1;
  logic signed [ACC_WIDTH-1:0]          r_y2;
  logic [OUT_WIDTH-1:0]                 r_d3;

  // The whole pipeline moves as one; S3 is the only stage that can block
  assign w_adv         = !r_v3 || m_axis.tready;
  assign w_accept      = s_axis.tvalid && w_adv;
  assign s_axis.tready = w_adv;

  assign m_axis.tdata  = r_d3;
  assign m_axis.tvalid = r_v3;
  assign m_axis.tlast  = r_l3;

`ifdef CONV_POSTPROC_NOISE_EN
  conv_noise_lfsr #(
    .ACC_WIDTH (ACC_WIDTH)
  ) u_noise (
    .clk         (clk),
    .reset       (reset),
    .advance     (w_accept),
    .noise_scale (noise_scale),
    .noise       (w_noise)
  );
`else
  logic w_unused_noise_scale;
  assign w_unused_noise_scale = ^noise_scale;
  assign w_noise              = '0;
`endif

  // S1: accumulator must be a clean sign extension of its 48 significant bits
  assign w_upper   = s_axis.tdata[AXIS_ACC_WIDTH-1:ACC_WIDTH-1];
  assign w_acc_bad = !((&w_upper) || !(|w_upper));
  assign w_acc     = s_axis.tdata[ACC_WIDTH-1:0];
  assign w_round   = (w_acc + C_HALF) >>> FRAC_SHIFT;

  // S2: noise then LeakyReLU with floor shift on negatives
  assign w_x = r_r1 + r_n1;
  assign w_y = w_x[ACC_WIDTH-1] ? (w_x >>> LEAKY_SHIFT) : w_x;

  // S3: clamp to the output pixel range
  assign w_sat_hi = (r_y2 > C_MAX);
  assign w_sat_lo = (r_y2 < C_MIN);
  assign w_clamp  = w_sat_hi ? C_MAX[OUT_WIDTH-1:0] :
                    w_sat_lo ? C_MIN[OUT_WIDTH-1:0] :
                               r_y2[OUT_WIDTH-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
      r_l1 <= 1'b0;
      r_l2 <= 1'b0;
      r_l3 <= 1'b0;
      r_r1 <= '0;
      r_n1 <= '0;
      r_y2 <= '0;
      r_d3 <= '0;
    end else if (w_adv) begin
      r_v1 <= s_axis.tvalid;
      r_l1 <= s_axis.tvalid && s_axis.tlast;
      r_r1 <= w_round;
      r_n1 <= w_noise;
      r_v2 <= r_v1;
      r_l2 <= r_l1;
      r_y2 <= w_y;
      r_v3 <= r_v2;
      r_l3 <= r_l2;
      r_d3 <= w_clamp;
    end
  end

  assign w_frame_len = 15'(image_size) * 15'(image_size);
  assign w_frame_hit = (pixel_count + 15'd1) == w_frame_len;

  // Clear wins over any flag set in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_flag    <= 1'b0;
      acc_err     <= 1'b0;
      tlast_err   <= 1'b0;
      pixel_count <= '0;
    end else if (clr_status) begin
      sat_flag    <= 1'b0;
      acc_err     <= 1'b0;
      tlast_err   <= 1'b0;
      pixel_count <= w_accept ? 15'd1 : 15'd0;
    end else begin
      if (w_adv && r_v2 && (w_sat_hi || w_sat_lo)) begin
        sat_flag <= 1'b1;
      end
      if (w_accept && w_acc_bad) begin
        acc_err <= 1'b1;
      end
      if (w_accept) begin
        if (s_axis.tlast || w_frame_hit) begin
          if (s_axis.tlast != w_frame_hit) begin
            tlast_err <= 1'b1;
          end
          pixel_count <= '0;
        end else begin
          pixel_count <= pixel_count + 15'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire
